keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE, default 4, meaning the number of consecutive stable clk_out cycles needed to accept a press or a release (legal range 2..15).
REQ-002 The block SHALL have parameter DWELL, default 3, meaning the clk_out cycles each row is driven during scanning (legal range 3..7).
REQ-003 The block SHALL have port clk_out, input, 1 bit: the scan clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous clear of the digit register.
REQ-006 The block SHALL have port cols, input, 4 bits: keypad columns, active-low, externally pulled up, asynchronous to clk_out.
REQ-007 The block SHALL have port rows, output, 4 bits: keypad row drive, active-low, one-cold.
REQ-008 The block SHALL have port key_code, output, 4 bits: last accepted key, equal to row*4+col.
REQ-009 The block SHALL have port key_valid, output, 1 bit: one-cycle pulse on each accepted press.
REQ-010 The block SHALL have port key_held, output, 1 bit: high while an accepted key is still down.
REQ-011 The block SHALL have ports dig0, dig1, dig2, dig3, output, 4 bits each: the last four accepted codes (dig0 newest), sized for the display driver's digit inputs.

Function
REQ-012 The block SHALL pass cols through a 2-flop synchronizer; "scol" denotes its output, and all decisions SHALL use scol only.
REQ-013 The block SHALL implement a state machine with states SCAN, DEBOUNCE, PRESSED and RELEASE, encoded in registers.
REQ-014 In SCAN, rows SHALL equal ~(1<<ridx); ridx SHALL advance 0->1->2->3->0 after every DWELL cycles, counted by a dwell counter that restarts at 0 on each advance.
REQ-015 In SCAN, scol SHALL be sampled only on the last dwell cycle of a row; if it is 4'b1111, the block SHALL advance the row.
REQ-016 If that sample is not 4'b1111, the block SHALL capture crow=ridx and ccol=the lowest index of any low bit of scol, freeze ridx, and enter DEBOUNCE with the counter at 1.
REQ-017 In DEBOUNCE, the counter SHALL increment each cycle in which scol[ccol]==0.
REQ-018 In DEBOUNCE, any cycle with scol[ccol]==1 SHALL return the block to SCAN, advancing ridx to the next row with the dwell counter at 0, and SHALL NOT produce key_valid.
REQ-019 When the counter reaches DEBOUNCE, the block SHALL enter PRESSED on the next edge.
REQ-020 On that same edge, key_code SHALL load {crow[1:0],ccol[1:0]}, key_valid SHALL be 1 for exactly that one cycle, and dig3<=dig2, dig2<=dig1, dig1<=dig0, dig0<=code.
REQ-021 key_held SHALL be 1 in PRESSED and RELEASE and 0 otherwise.
REQ-022 In PRESSED, rows SHALL stay on crow; scol[ccol]==1 SHALL move the block to RELEASE with the counter at 1.
REQ-023 In RELEASE, the counter SHALL increment while scol[ccol]==1; scol[ccol]==0 SHALL return the block to PRESSED without a new key_valid (bounce on release).
REQ-024 When the RELEASE count reaches DEBOUNCE, the block SHALL enter SCAN with ridx=0 and the dwell counter at 0.
REQ-025 Additional keys pressed while in PRESSED or RELEASE SHALL be ignored; only the captured key matters, with no rollover.
REQ-026 clr=1 SHALL zero dig0..dig3 on the next edge in any state without altering the FSM; if clr coincides with an accept, the digits SHALL clear and the new code SHALL still appear on key_code and key_valid.
REQ-027 key_code SHALL hold its value between accepts.

Reset
REQ-028 Reset assertion SHALL immediately force state SCAN, ridx=0, rows=4'b1110, all counters 0, synchronizer flops to 1, key_code=0, key_valid=0, key_held=0 and dig0..dig3=0.
REQ-029 Reset mid-debounce or mid-press SHALL discard the pending key with no key_valid.
REQ-030 Scanning SHALL resume at row 0 on the first edge after reset deasserts.

Verification
REQ-031 No key pressed for 24 cycles (defaults) -> the bench SHALL observe rows 1110x3, 1101x3, 1011x3, 0111x3, repeating, and key_valid never 1.
REQ-032 Clean hold of row 2 / col 1 -> the bench SHALL observe exactly one key_valid with key_code=4'd9, dig0=9, and key_held=1 until 4 cycles after the key opens.
REQ-033 Press bouncing (low 2 cycles, high 1 cycle, then stable) on row 0 / col 3 -> the bench SHALL observe the first attempt aborted, then one key_valid with key_code=3, never two.
REQ-034 Keys 1,2,3,4,5 accepted in sequence -> the bench SHALL observe dig3..dig0=2,3,4,5; then clr -> all digits 0 while key_code stays 5.
REQ-035 Row 1 / col 0 and col 2 pressed together -> the bench SHALL observe key_code=4; a second key pressed while the first is held SHALL produce no key_valid.
REQ-036 Reset asserted 2 cycles into DEBOUNCE -> the bench SHALL observe rows=1110 asynchronously, key_valid=0, digits unchanged at 0.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce and
// a four-deep history of accepted key codes for a display driver.
//
// Ports:
//   clk_out   - scan clock, all state updates on its rising edge
//   reset     - asynchronous, active-high reset
//   clr       - synchronous clear of dig0..dig3
//   cols      - keypad columns, active-low, asynchronous to clk_out
//   rows      - keypad row drive, active-low, one-cold
//   key_code  - last accepted key, row*4+col
//   key_valid - one-cycle pulse per accepted press
//   key_held  - high while the accepted key is still down
//   dig0..3   - last four accepted codes, dig0 newest
module keypad_scanner #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned DWELL    = 3
) (
    input  logic       clk_out,
    input  logic       reset,
    input  logic       clr,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DWELL_W = 3;
    localparam int unsigned IDX_W   = 2;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [CNT_W-1:0]   DEB_DONE   = CNT_W'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ridx, ridx_nxt;
    logic [DWELL_W-1:0] dcnt, dcnt_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   crow, crow_nxt;
    logic [IDX_W-1:0]   ccol, ccol_nxt;
    logic [3:0]         sync1, scol;
    logic [3:0]         rows_nxt, key_code_nxt;
    logic               key_valid_nxt, key_held_nxt;
    logic [3:0]         dig0_nxt, dig1_nxt, dig2_nxt, dig3_nxt;
    logic               key_open_c;
    logic               accept_c;

    // Lowest-numbered closed column wins when several are low together.
    function automatic logic [IDX_W-1:0] lowest_low(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    // State and output registers; the synchronizer idles at "no key".
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            state     <= ST_SCAN;
            ridx      <= '0;
            dcnt      <= '0;
            cnt       <= '0;
            crow      <= '0;
            ccol      <= '0;
            sync1     <= 4'b1111;
            scol      <= 4'b1111;
            rows      <= 4'b1110;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            dig0      <= '0;
            dig1      <= '0;
            dig2      <= '0;
            dig3      <= '0;
        end else begin
            state     <= state_nxt;
            ridx      <= ridx_nxt;
            dcnt      <= dcnt_nxt;
            cnt       <= cnt_nxt;
            crow      <= crow_nxt;
            ccol      <= ccol_nxt;
            sync1     <= cols;
            scol      <= sync1;
            rows      <= rows_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            key_held  <= key_held_nxt;
            dig0      <= dig0_nxt;
            dig1      <= dig1_nxt;
            dig2      <= dig2_nxt;
            dig3      <= dig3_nxt;
        end
    end

    // Only the captured column is watched once a key has been found.
    assign key_open_c = scol[ccol];

    // Next-state and output logic.
    always_comb begin
        state_nxt     = state;
        ridx_nxt      = ridx;
        dcnt_nxt      = dcnt;
        cnt_nxt       = cnt;
        crow_nxt      = crow;
        ccol_nxt      = ccol;
        accept_c      = 1'b0;
        key_code_nxt  = key_code;
        key_valid_nxt = 1'b0;
        dig0_nxt      = dig0;
        dig1_nxt      = dig1;
        dig2_nxt      = dig2;
        dig3_nxt      = dig3;

        case (state)
            ST_SCAN: begin
                if (dcnt == DWELL_LAST) begin
                    dcnt_nxt = '0;
                    if (scol == 4'b1111) begin
                        ridx_nxt = ridx + 2'd1;
                    end else begin
                        crow_nxt  = ridx;
                        ccol_nxt  = lowest_low(scol);
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ST_DEBOUNCE;
                    end
                end else begin
                    dcnt_nxt = dcnt + DWELL_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (cnt == DEB_DONE) begin
                    accept_c  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_PRESSED;
                end else if (key_open_c) begin
                    // Bounce during press: abandon and move on to the next row.
                    ridx_nxt  = ridx + 2'd1;
                    dcnt_nxt  = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_SCAN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (key_open_c) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (cnt == DEB_DONE) begin
                    ridx_nxt  = '0;
                    dcnt_nxt  = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_SCAN;
                end else if (key_open_c) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end else begin
                    // Bounce during release: key still counts as held.
                    cnt_nxt   = '0;
                    state_nxt = ST_PRESSED;
                end
            end
            default: begin
                ridx_nxt  = '0;
                dcnt_nxt  = '0;
                cnt_nxt   = '0;
                state_nxt = ST_SCAN;
            end
        endcase

        if (accept_c) begin
            key_code_nxt  = {crow, ccol};
            key_valid_nxt = 1'b1;
            dig3_nxt      = dig2;
            dig2_nxt      = dig1;
            dig1_nxt      = dig0;
            dig0_nxt      = {crow, ccol};
        end

        // Clear wins over the history shift but not over key_code/key_valid.
        if (clr) begin
            dig0_nxt = '0;
            dig1_nxt = '0;
            dig2_nxt = '0;
            dig3_nxt = '0;
        end

        key_held_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_RELEASE);
        // ridx stays frozen on the captured row outside SCAN, so it drives rows throughout.
        rows_nxt = ~(4'b0001 << ridx_nxt);
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner. A behavioural
// keypad matrix closes columns for pressed keys on the driven row; expected
// key codes are queued at press time and compared on each key_valid pulse.
module tb_keypad_scanner;

    logic       clk_out;
    logic       reset;
    logic       clr;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [3:0] dig0, dig1, dig2, dig3;

    logic [15:0] keys;
    int          n_chk;
    int          n_pass;
    int          n_valid;
    int          exp_code;
    int          exp_q[$];

    keypad_scanner #(.DEBOUNCE(4), .DWELL(3)) dut (
        .clk_out   (clk_out),
        .reset     (reset),
        .clr       (clr),
        .cols      (cols),
        .rows      (rows),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .dig0      (dig0),
        .dig1      (dig1),
        .dig2      (dig2),
        .dig3      (dig3)
    );

    initial clk_out = 1'b0;
    always #5 clk_out = ~clk_out;

    // Keypad matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        cols = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !rows[r]) cols[c] = 1'b0;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Scoreboard: every key_valid pops one expected code.
    always @(negedge clk_out) begin
        if (!reset && key_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                exp_code = exp_q.pop_front();
                check("sb_code", int'(key_code), exp_code);
            end
        end
    end

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!key_valid && n < 100) begin
            @(negedge clk_out);
            n++;
        end
        check(tag, int'(n < 100), 1);
    endtask

    task automatic wait_released(input string tag);
        int n = 0;
        while (key_held && n < 50) begin
            @(negedge clk_out);
            n++;
        end
        check(tag, int'(n < 50), 1);
        repeat (4) @(negedge clk_out);
    endtask

    // Stop at the negedge just after the given row pattern starts being driven.
    task automatic align_row(input logic [3:0] pat, input string tag);
        int n = 0;
        while (rows == pat && n < 50) begin
            @(negedge clk_out);
            n++;
        end
        while (rows != pat && n < 100) begin
            @(negedge clk_out);
            n++;
        end
        check(tag, int'(n < 100), 1);
    endtask

    task automatic tap_key(input int k);
        exp_q.push_back(k);
        keys[k] = 1'b1;
        wait_valid($sformatf("tap_valid_%0d", k));
        keys[k] = 1'b0;
        wait_released($sformatf("tap_release_%0d", k));
    endtask

    initial begin
        int v0;
        n_chk   = 0;
        n_pass  = 0;
        n_valid = 0;
        keys    = '0;
        clr     = 1'b0;
        reset   = 1'b1;

        // Reset state
        #1;
        check("rst_rows", int'(rows), 4'b1110);
        check("rst_code", int'(key_code), 0);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        check("rst_digs", int'({dig3, dig2, dig1, dig0}), 0);
        repeat (2) @(negedge clk_out);
        reset = 1'b0;

        // Idle scan pattern: each row driven for three cycles in turn
        for (int i = 0; i < 24; i++) begin
            logic [3:0] exp_rows;
            exp_rows = ~(4'b0001 << ((i / 3) % 4));
            check($sformatf("idle_rows_%0d", i), int'(rows), int'(exp_rows));
            @(negedge clk_out);
        end
        check("idle_no_valid", n_valid, 0);

        // Clean hold of row 2 / col 1
        v0 = n_valid;
        exp_q.push_back(9);
        keys[9] = 1'b1;
        wait_valid("k9_valid");
        check("k9_code", int'(key_code), 9);
        check("k9_dig0", int'(dig0), 9);
        check("k9_held", int'(key_held), 1);
        repeat (20) @(negedge clk_out);
        check("k9_code_hold", int'(key_code), 9);
        check("k9_held_long", int'(key_held), 1);
        keys[9] = 1'b0;
        repeat (4) @(negedge clk_out);
        check("k9_held_after4", int'(key_held), 1);
        repeat (4) @(negedge clk_out);
        check("k9_held_off", int'(key_held), 0);
        check("k9_one_valid", n_valid - v0, 1);
        repeat (6) @(negedge clk_out);

        // Bouncing press on row 0 / col 3: low 2, high 1, then stable
        v0 = n_valid;
        align_row(4'b1110, "b3_align");
        keys[3] = 1'b1;
        repeat (2) @(negedge clk_out);
        keys[3] = 1'b0;
        @(negedge clk_out);
        keys[3] = 1'b1;
        @(negedge clk_out);
        check("b3_capturing", int'(rows), 4'b1110);
        @(negedge clk_out);
        check("b3_aborted", int'(rows), 4'b1101);
        check("b3_no_valid_yet", n_valid - v0, 0);
        exp_q.push_back(3);
        wait_valid("b3_valid");
        check("b3_code", int'(key_code), 3);
        repeat (15) @(negedge clk_out);
        keys[3] = 1'b0;
        wait_released("b3_release");
        check("b3_one_valid", n_valid - v0, 1);

        // Keys 1..5 in sequence fill the history, then clear it
        for (int k = 1; k <= 5; k++) tap_key(k);
        check("hist_dig3", int'(dig3), 2);
        check("hist_dig2", int'(dig2), 3);
        check("hist_dig1", int'(dig1), 4);
        check("hist_dig0", int'(dig0), 5);
        clr = 1'b1;
        @(negedge clk_out);
        clr = 1'b0;
        check("clr_digs", int'({dig3, dig2, dig1, dig0}), 0);
        check("clr_code", int'(key_code), 5);
        repeat (3) @(negedge clk_out);

        // Reset two cycles into debounce of row 1 / col 1
        v0 = n_valid;
        align_row(4'b1101, "rd_align");
        keys[5] = 1'b1;
        repeat (5) @(negedge clk_out);
        check("rd_rows_pre", int'(rows), 4'b1101);
        reset = 1'b1;
        #1;
        check("rd_rows", int'(rows), 4'b1110);
        check("rd_valid", int'(key_valid), 0);
        check("rd_held", int'(key_held), 0);
        check("rd_code", int'(key_code), 0);
        check("rd_digs", int'({dig3, dig2, dig1, dig0}), 0);
        keys[5] = 1'b0;
        repeat (2) @(negedge clk_out);
        reset = 1'b0;
        repeat (30) @(negedge clk_out);
        check("rd_no_valid", n_valid - v0, 0);

        // Row 1 cols 0 and 2 together, then another key while held
        v0 = n_valid;
        exp_q.push_back(4);
        keys[4] = 1'b1;
        keys[6] = 1'b1;
        wait_valid("two_valid");
        check("two_code", int'(key_code), 4);
        keys[13] = 1'b1;
        repeat (30) @(negedge clk_out);
        check("two_held", int'(key_held), 1);
        check("two_rows", int'(rows), 4'b1101);
        check("two_one_valid", n_valid - v0, 1);
        check("two_code_hold", int'(key_code), 4);
        keys = '0;
        wait_released("two_release");
        repeat (20) @(negedge clk_out);
        check("two_final_valid", n_valid - v0, 1);

        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
